// File: rtl/microarch_trace_buffer.sv
// Pipeline trace capture: per-cycle stage/lane valid+PC snapshots packed into timestamped
// records, queued in a FIFO drained over valid/ready, plus end-of-test marker detection.
module microarch_trace_buffer #(
    parameter int          LANES       = 2,
    parameter int          STAGES      = 7,
    parameter int          DEC_IDX     = 1,
    parameter int          WB_IDX      = STAGES - 1,
    parameter int          PC_W        = 32,
    parameter int          DEPTH       = 16,
    parameter int          TS_W        = 16,
    parameter int          DCNT_W      = 16,
    parameter logic [31:0] FINISH_INSN = 32'h00002013
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [STAGES-1:0]              stage_en_i,
    input  logic [STAGES*LANES-1:0]        stage_valid_i,
    input  logic [STAGES*LANES*PC_W-1:0]   stage_pc_i,
    input  logic [LANES*32-1:0]            dec_insn_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [TS_W-1:0]                out_ts_o,
    output logic [STAGES*LANES-1:0]        out_mask_o,
    output logic [STAGES*LANES*PC_W-1:0]   out_pc_o,
    output logic                           out_gap_o,
    output logic [DCNT_W-1:0]              drop_count_o,
    output logic                           overflow_o,
    output logic                           finish_o,
    output logic                           done_o
);

    localparam int NSLOT = STAGES * LANES;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [TS_W-1:0]       ts;
        logic [NSLOT-1:0]      mask;
        logic [NSLOT*PC_W-1:0] pc;
        logic                  gap;
    } rec_t;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [DCNT_W-1:0] drop_q, drop_d;
    logic              overflow_q, overflow_d;
    logic              gap_q, gap_d;
    logic [LANES-1:0]  armed_q, armed_d;
    logic              finish_q, finish_d;
    logic              done_q, done_d;
    rec_t              mem_q [DEPTH];

    logic [NSLOT-1:0]      mask;
    logic [NSLOT*PC_W-1:0] pc_masked;
    logic [LANES-1:0]      dec_hit, wb_hit;
    logic                  empty, full, pop, push_req, push, drop, fire;
    rec_t                  rec_w, head;

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        assign mask[k] = stage_valid_i[k] & stage_en_i[k/LANES];
        assign pc_masked[k*PC_W +: PC_W] = mask[k] ? stage_pc_i[k*PC_W +: PC_W] : '0;
    end

    // Detection looks at raw valids; the capture enables only shape the trace.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign dec_hit[l] = stage_valid_i[DEC_IDX*LANES+l] && (dec_insn_i[l*32 +: 32] == FINISH_INSN);
        assign wb_hit[l]  = stage_valid_i[WB_IDX*LANES+l] && armed_q[l];
    end

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop      = !empty && out_ready_i;
    assign push_req = (|mask) && !done_q;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign fire     = (|wb_hit) && !done_q;

    assign rec_w = '{ts: ts_q, mask: mask, pc: pc_masked, gap: gap_q};

    always_comb begin
        ts_d       = ts_q + 1'b1;
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop  ? rd_q + 1'b1 : rd_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        gap_d      = gap_q;
        if (drop) begin
            overflow_d = 1'b1;
            gap_d      = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end else if (push) begin
            gap_d = 1'b0;
        end
        finish_d = fire;
        done_d   = done_q | fire;
        armed_d  = fire ? '0 : (armed_q | dec_hit);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            gap_q      <= 1'b0;
            armed_q    <= '0;
            finish_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            gap_q      <= gap_d;
            armed_q    <= armed_d;
            finish_q   <= finish_d;
            done_q     <= done_d;
        end
    end

    // On a full push+pop the write lands in the slot being popped, so the head stays intact.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wr_q[AW-1:0]] <= rec_w;
    end

    assign head         = mem_q[rd_q[AW-1:0]];
    assign out_valid_o  = !empty;
    assign out_ts_o     = head.ts;
    assign out_mask_o   = head.mask;
    assign out_pc_o     = head.pc;
    assign out_gap_o    = head.gap;
    assign drop_count_o = drop_q;
    assign overflow_o   = overflow_q;
    assign finish_o     = finish_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_microarch_trace_buffer.sv
// Directed bench for microarch_trace_buffer: capture table plus overflow, finish and reset sequences.
module tb_microarch_trace_buffer;
    localparam int LANES = 2, STAGES = 7, PC_W = 32, DEPTH = 16, TS_W = 16, DCNT_W = 16;
    localparam int NSLOT = STAGES * LANES;
    localparam int CW    = NSLOT * PC_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [STAGES-1:0]    en;
    logic [NSLOT-1:0]     valid;
    logic [CW-1:0]        pc;
    logic [LANES*32-1:0]  insn;
    logic                 ready;
    logic                 out_valid, out_gap, overflow, finish, done;
    logic [TS_W-1:0]      out_ts;
    logic [NSLOT-1:0]     out_mask;
    logic [CW-1:0]        out_pc;
    logic [DCNT_W-1:0]    drop_count;

    int errors = 0;
    int checks = 0;
    int ts_now = 0;

    always #5 clk = ~clk;

    microarch_trace_buffer #(.LANES(LANES), .STAGES(STAGES), .PC_W(PC_W), .DEPTH(DEPTH),
                             .TS_W(TS_W), .DCNT_W(DCNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .stage_en_i(en), .stage_valid_i(valid), .stage_pc_i(pc),
        .dec_insn_i(insn), .out_valid_o(out_valid), .out_ready_i(ready), .out_ts_o(out_ts),
        .out_mask_o(out_mask), .out_pc_o(out_pc), .out_gap_o(out_gap), .drop_count_o(drop_count),
        .overflow_o(overflow), .finish_o(finish), .done_o(done));

    typedef struct {
        logic [STAGES-1:0] en;
        logic [NSLOT-1:0]  valid;
        logic [31:0]       base;
        logic [NSLOT-1:0]  exp_mask;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] pcs(input logic [31:0] base);
        logic [CW-1:0] r;
        for (int k = 0; k < NSLOT; k++) r[k*PC_W +: PC_W] = base + 32'(4*k);
        return r;
    endfunction

    function automatic logic [CW-1:0] exp_pc(input logic [NSLOT-1:0] m, input logic [31:0] base);
        logic [CW-1:0] r;
        for (int k = 0; k < NSLOT; k++) r[k*PC_W +: PC_W] = m[k] ? base + 32'(4*k) : 32'h0;
        return r;
    endfunction

    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) ts_now = 0;
        else   ts_now = (ts_now + 1) % (1 << TS_W);
    endtask

    task automatic chk_rec(input string nm, input logic [NSLOT-1:0] m, input logic [31:0] base,
                           input logic gap, input int ts);
        chk({nm, ".valid"}, CW'(out_valid), CW'(1));
        chk({nm, ".ts"},    CW'(out_ts),    CW'(ts));
        chk({nm, ".mask"},  CW'(out_mask),  CW'(m));
        chk({nm, ".pc"},    out_pc,         exp_pc(m, base));
        chk({nm, ".gap"},   CW'(out_gap),   CW'(gap));
    endtask

    initial begin
        int t2_ts, t3_ts, t5_ts;
        tbl[0] = '{7'h7F, 14'h0003, 32'h0000_1000, 14'h0003};
        tbl[1] = '{7'h40, 14'h3FFF, 32'h0000_2000, 14'h3000};
        tbl[2] = '{7'h40, 14'h0FFF, 32'h0000_3000, 14'h0000};
        tbl[3] = '{7'h00, 14'h3FFF, 32'h0000_4000, 14'h0000};
        tbl[4] = '{7'h05, 14'h0035, 32'h0000_5000, 14'h0031};
        tbl[5] = '{7'h7F, 14'h2001, 32'h0000_6000, 14'h2001};
        tbl[6] = '{7'h7F, 14'h0000, 32'h0000_7000, 14'h0000};
        tbl[7] = '{7'h22, 14'h3FFF, 32'h0000_8000, 14'h0C0C};

        rst = 1'b1; en = '0; valid = '0; pc = '0; insn = '0; ready = 1'b0;
        step();
        chk("rst.valid",    CW'(out_valid),  CW'(0));
        chk("rst.drop",     CW'(drop_count), CW'(0));
        chk("rst.overflow", CW'(overflow),   CW'(0));
        chk("rst.finish",   CW'(finish),     CW'(0));
        chk("rst.done",     CW'(done),       CW'(0));

        // Single capture at ts=5, latency one cycle.
        rst = 1'b0;
        repeat (5) step();
        en = '1; valid = 14'h0001; pc = pcs(32'h80);
        step();
        valid = '0;
        chk_rec("t1", 14'h0001, 32'h80, 1'b0, 5);
        ready = 1'b1;
        step();
        chk("t1.drained", CW'(out_valid), CW'(0));

        // Mask / enable table; each record is popped as the next vector is applied.
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en; valid = tbl[i].valid; pc = pcs(tbl[i].base);
            step();
            if (tbl[i].exp_mask != '0) chk_rec($sformatf("tbl%0d", i), tbl[i].exp_mask, tbl[i].base, 1'b0, ts_now - 1);
            else chk($sformatf("tbl%0d.nopush", i), CW'(out_valid), CW'(0));
        end
        valid = '0;
        step();
        chk("tbl.drained", CW'(out_valid), CW'(0));

        // Overflow: DEPTH+3 pushes with no consumer.
        ready = 1'b0; en = '1;
        t2_ts = ts_now;
        for (int i = 0; i < DEPTH + 3; i++) begin
            valid = 14'h0001; pc = pcs(32'h100 + 32'(i));
            step();
        end
        valid = '0;
        chk("t2.drop",     CW'(drop_count), CW'(3));
        chk("t2.overflow", CW'(overflow),   CW'(1));
        chk_rec("t2.head", 14'h0001, 32'h100, 1'b0, t2_ts);

        // Full FIFO with simultaneous push and pop: no drop, new record carries gap.
        ready = 1'b1; valid = 14'h0001; pc = pcs(32'h200);
        t3_ts = ts_now;
        step();
        valid = '0;
        chk("t3.drop", CW'(drop_count), CW'(3));
        for (int k = 0; k < DEPTH; k++) begin
            if (k < DEPTH - 1) chk_rec($sformatf("t3.q%0d", k), 14'h0001, 32'h101 + 32'(k), 1'b0, t2_ts + 1 + k);
            else               chk_rec("t3.last", 14'h0001, 32'h200, 1'b1, t3_ts);
            step();
        end
        chk("t3.empty",    CW'(out_valid), CW'(0));
        chk("t3.overflow", CW'(overflow),  CW'(1));

        // Finish: lane1 marker decoded at t (wb lane1 also valid at t, must not count).
        rst = 1'b1; step(); rst = 1'b0;
        ready = 1'b0; en = '1; pc = pcs(32'h300);
        valid = 14'h2008; insn = {32'h00002013, 32'h0};
        t5_ts = ts_now;
        step();
        valid = '0; insn = '0;
        chk("t5.same_cycle", CW'(finish), CW'(0));
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("t5.nofin%0d", i), CW'(finish), CW'(0));
        end
        valid = 14'h2000;
        step();
        chk("t5.finish", CW'(finish), CW'(1));
        chk("t5.done",   CW'(done),   CW'(1));
        valid = '1;
        step();
        chk("t5.pulse",      CW'(finish), CW'(0));
        chk("t5.done_stick", CW'(done),   CW'(1));
        step();
        valid = '0;
        chk_rec("t5.rec0", 14'h2008, 32'h300, 1'b0, t5_ts);
        ready = 1'b1;
        step();
        chk_rec("t5.rec1", 14'h2000, 32'h300, 1'b0, t5_ts + 5);
        step();
        chk("t5.no_more", CW'(out_valid), CW'(0));

        // Mid-operation reset with 4 queued records and drop_count=2.
        rst = 1'b1; step(); rst = 1'b0;
        ready = 1'b0; valid = 14'h0001; pc = pcs(32'h400);
        repeat (DEPTH + 2) step();
        valid = '0;
        chk("t6.drop", CW'(drop_count), CW'(2));
        ready = 1'b1;
        repeat (DEPTH - 4) step();
        ready = 1'b0;
        chk("t6.queued", CW'(out_valid), CW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6.valid",    CW'(out_valid),  CW'(0));
        chk("t6.drop0",    CW'(drop_count), CW'(0));
        chk("t6.overflow", CW'(overflow),   CW'(0));
        chk("t6.done",     CW'(done),       CW'(0));
        valid = 14'h0001; pc = pcs(32'h500);
        step();
        valid = '0;
        chk_rec("t6.ts0", 14'h0001, 32'h500, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
